// File: rtl/ir_pkg.sv
// Shared definitions for the NEC IR frame checker: field offsets,
// the buffered key-event entry layout and the default repeat window.
package ir_pkg;

   localparam int ADDR_LSB  = 0;
   localparam int NADDR_LSB = 8;
   localparam int CMD_LSB   = 16;
   localparam int NCMD_LSB  = 24;

   // 120 ms at 50 MHz
   localparam int unsigned REPEAT_WINDOW_DEFAULT = 6_000_000;

   typedef struct packed {
      logic       is_repeat;
      logic [7:0] cmd;
      logic [7:0] addr;
   } ir_entry_t;

endpackage

// File: rtl/ir_sync_fifo.sv
// Synchronous show-ahead FIFO with wrap-bit pointers; a push into a full
// FIFO is accepted only when a pop happens in the same cycle.
module ir_sync_fifo #(
   parameter int WIDTH = 17,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push_i,
   input  logic             pop_i,
   input  logic [WIDTH-1:0] wdata_i,
   output logic [WIDTH-1:0] rdata_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW:0]      wr_q, wr_d;
   logic [AW:0]      rd_q, rd_d;
   logic             do_push;
   logic             do_pop;

   assign full_o  = (wr_q[AW-1:0] == rd_q[AW-1:0]) && (wr_q[AW] != rd_q[AW]);
   assign empty_o = (wr_q == rd_q);
   assign do_pop  = pop_i && !empty_o;
   assign do_push = push_i && (!full_o || do_pop);
   assign rdata_o = mem_q[rd_q[AW-1:0]];

   always_comb begin
      wr_d = wr_q;
      rd_d = rd_q;
      if (do_push) wr_d = wr_q + (AW+1)'(1);
      if (do_pop)  rd_d = rd_q + (AW+1)'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_q <= '0;
         rd_q <= '0;
      end else begin
         wr_q <= wr_d;
         rd_q <= rd_d;
      end
   end

   // Storage needs no reset; emptiness is tracked by the pointers alone.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_q[AW-1:0]] <= wdata_i;
   end

endmodule

// File: rtl/ir_frame_checker.sv
// Validates decoded NEC words, tags key repeats within a time window and
// buffers accepted key events; keeps saturating error and drop counters.
module ir_frame_checker
   import ir_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH    = 4,
   parameter int unsigned REPEAT_WINDOW = REPEAT_WINDOW_DEFAULT,
   parameter int unsigned CNT_W         = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             frame_valid_in,
   input  logic [31:0]      frame_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [7:0]       out_addr,
   output logic [7:0]       out_cmd,
   output logic             out_repeat,
   output logic [CNT_W-1:0] err_addr_cnt,
   output logic [CNT_W-1:0] err_cmd_cnt,
   output logic [CNT_W-1:0] drop_cnt
);

   localparam int WIN_W = $clog2(REPEAT_WINDOW + 1);

   logic             prev_q, prev_d;
   logic [31:0]      cap_q, cap_d;
   logic             cap_vld_q, cap_vld_d;
   logic [WIN_W-1:0] win_q, win_d;
   logic [15:0]      last_q, last_d;
   logic [CNT_W-1:0] err_addr_q, err_addr_d;
   logic [CNT_W-1:0] err_cmd_q, err_cmd_d;
   logic [CNT_W-1:0] drop_q, drop_d;

   logic      new_frame;
   logic      addr_ok, cmd_ok, accept;
   logic      fifo_full, fifo_empty, pop;
   ir_entry_t push_entry, head_entry;

   assign new_frame = frame_valid_in & ~prev_q;
   assign addr_ok   = (cap_q[NADDR_LSB +: 8] == ~cap_q[ADDR_LSB +: 8]);
   assign cmd_ok    = (cap_q[NCMD_LSB +: 8] == ~cap_q[CMD_LSB +: 8]);
   assign accept    = cap_vld_q & addr_ok & cmd_ok;
   assign pop       = out_valid & out_ready;

   always_comb begin
      push_entry.addr      = cap_q[ADDR_LSB +: 8];
      push_entry.cmd       = cap_q[CMD_LSB +: 8];
      push_entry.is_repeat = ({push_entry.cmd, push_entry.addr} == last_q) && (win_q != '0);
   end

   // Next-state for capture, repeat tracking and the saturating counters.
   // Window and last-code updates happen on acceptance even if the push is dropped.
   always_comb begin
      prev_d     = frame_valid_in;
      cap_d      = new_frame ? frame_in : cap_q;
      cap_vld_d  = new_frame;
      win_d      = win_q;
      last_d     = last_q;
      err_addr_d = err_addr_q;
      err_cmd_d  = err_cmd_q;
      drop_d     = drop_q;

      if (win_q != '0) win_d = win_q - WIN_W'(1);

      if (accept) begin
         win_d  = WIN_W'(REPEAT_WINDOW);
         last_d = {push_entry.cmd, push_entry.addr};
         if (fifo_full && !pop && drop_q != '1) drop_d = drop_q + CNT_W'(1);
      end

      if (cap_vld_q && !addr_ok && err_addr_q != '1) err_addr_d = err_addr_q + CNT_W'(1);
      if (cap_vld_q && !cmd_ok && err_cmd_q != '1)   err_cmd_d  = err_cmd_q + CNT_W'(1);
   end

   // prev resets high so a flag already asserted at reset release is ignored.
   always_ff @(posedge clk) begin
      if (rst) begin
         prev_q     <= 1'b1;
         cap_q      <= '0;
         cap_vld_q  <= 1'b0;
         win_q      <= '0;
         last_q     <= '0;
         err_addr_q <= '0;
         err_cmd_q  <= '0;
         drop_q     <= '0;
      end else begin
         prev_q     <= prev_d;
         cap_q      <= cap_d;
         cap_vld_q  <= cap_vld_d;
         win_q      <= win_d;
         last_q     <= last_d;
         err_addr_q <= err_addr_d;
         err_cmd_q  <= err_cmd_d;
         drop_q     <= drop_d;
      end
   end

   ir_sync_fifo #(
      .WIDTH ($bits(ir_entry_t)),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (accept),
      .pop_i   (pop),
      .wdata_i (push_entry),
      .rdata_o (head_entry),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   // Head fields are forced to zero while empty so reset leaves them clean.
   assign out_valid    = ~fifo_empty;
   assign out_addr     = out_valid ? head_entry.addr : 8'h00;
   assign out_cmd      = out_valid ? head_entry.cmd : 8'h00;
   assign out_repeat   = out_valid & head_entry.is_repeat;
   assign err_addr_cnt = err_addr_q;
   assign err_cmd_cnt  = err_cmd_q;
   assign drop_cnt     = drop_q;

endmodule
